// File: rtl/wb_pkg.sv
// Shared constants and helpers for the writeback select path.
// Source indices and immediate extension are used by wb_select_pipe.
package wb_pkg;

    localparam int SEL_ALU   = 0;
    localparam int SEL_MEM   = 1;
    localparam int EXT_MAX_W = 64;

    // The immediate sits directly after the last full-width source.
    function automatic int sel_imm(input int nsrc);
        return nsrc;
    endfunction

    // Extends the low imm_w bits of imm to data_w bits; bits above data_w are zero.
    function automatic logic [EXT_MAX_W-1:0] ext_imm(
        input logic [EXT_MAX_W-1:0] imm,
        input logic                 is_signed,
        input int                   data_w,
        input int                   imm_w
    );
        logic [EXT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < EXT_MAX_W; i++) begin
            if (i < imm_w)
                r[i] = imm[i];
            else if (i < data_w)
                r[i] = is_signed & imm[imm_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready register stage: a main register driving the output
// and a skid register that absorbs one beat while the consumer stalls.
module wb_skid_buffer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         accept;
    logic         xfer;

    assign in_ready = !skid_valid && !rst;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // An accept implies the skid is empty, so accept and skid-drain never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (accept) begin
            if (!out_valid || xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end else if (xfer) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_select_pipe.sv
// Writeback select: picks one of NSRC sources or the extended immediate and
// registers it through a skid buffer; illegal selects are consumed and flagged.
module wb_select_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8,
    parameter int NSRC   = 2,
    parameter int SEL_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [IMM_W-1:0]       imm_data,
    input  logic                   imm_signed,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   err_clr,
    output logic                   sel_err
);

    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(sel_imm(NSRC));

    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] imm_ext;
    logic              sel_legal;
    logic              illegal_acc;

    assign imm_ext     = DATA_W'(ext_imm(EXT_MAX_W'(imm_data), imm_signed, DATA_W, IMM_W));
    assign sel_legal   = (sel <= SEL_IMM);
    assign illegal_acc = in_valid && in_ready && !sel_legal;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SEL_W'(i))
                sel_data = src_data[i*DATA_W +: DATA_W];
        end
        if (sel == SEL_IMM)
            sel_data = imm_ext;
    end

    // A new illegal accept outranks a clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            sel_err <= 1'b0;
        else if (illegal_acc)
            sel_err <= 1'b1;
        else if (err_clr)
            sel_err <= 1'b0;
    end

    wb_skid_buffer #(
        .W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid && sel_legal),
        .in_data  (sel_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

endmodule

// File: tb/tb_wb_select_pipe.sv
// Scoreboard bench for wb_select_pipe: the driver queues expected beats on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_wb_select_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_data;
    logic [7:0]  imm_data;
    logic        imm_signed;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err_clr;
    logic        sel_err;

    typedef struct {
        logic [15:0] data;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   xq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    wb_select_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .imm_data  (imm_data),
        .imm_signed(imm_signed),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            xq.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %0h expected no beat", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", {16'h0, out_data}, {16'h0, e.data});
                if (e.lat)
                    chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one beat starting just after a posedge; returns just after the accepting edge.
    task automatic send(input logic [1:0] s, input logic [15:0] alu, input logic [15:0] mem,
                        input logic [7:0] imm, input logic sg, input logic [15:0] exp,
                        input bit lat);
        int n;
        sel        = s;
        src_data   = {mem, alu};
        imm_data   = imm;
        imm_signed = sg;
        in_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
        end else if (s <= 2'd2) begin
            sb.push_back('{exp, cyc + 1, lat});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b1; sel = 2'd0; src_data = 32'h0000_AAAA;
        imm_data = 8'h0; imm_signed = 1'b0; out_ready = 1'b1; err_clr = 1'b0;

        // Reset with in_valid high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Extension and plain source selection
        send(2'd2, 16'h0, 16'h0, 8'h80, 1'b1, 16'hFF80, 1);
        send(2'd2, 16'h0, 16'h0, 8'h80, 1'b0, 16'h0080, 1);
        send(2'd2, 16'h0, 16'h0, 8'h7F, 1'b1, 16'h007F, 1);
        send(2'd0, 16'h1234, 16'h5678, 8'hFF, 1'b1, 16'h1234, 1);
        send(2'd1, 16'h1234, 16'hBEEF, 8'hFF, 1'b1, 16'hBEEF, 1);
        drain();

        // Backpressure: fill main and skid, hold a third beat off
        out_ready = 1'b0;
        send(2'd0, 16'h1234, 16'h0, 8'h0, 1'b0, 16'h1234, 0);
        send(2'd1, 16'h0, 16'hBEEF, 8'h0, 1'b0, 16'hBEEF, 0);
        sel = 2'd0; src_data = {16'h0, 16'h5555}; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_hold_data", out_data, 16'h1234);
        @(negedge clk);
        chk("bp_in_ready_still_low", in_ready, 0);
        chk("bp_hold_data2", out_data, 16'h1234);
        chk("bp_hold_valid", out_valid, 1);
        xq.delete();
        @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("bp_third_ready", in_ready, 1);
        sb.push_back('{16'h5555, cyc + 1, 1'b1});
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("bp_xfer_count", xq.size(), 3);
        if (xq.size() == 3) begin
            chk("bp_consec_1", xq[1] - xq[0], 1);
            chk("bp_consec_2", xq[2] - xq[1], 1);
        end

        // Illegal select and sticky error flag
        send(2'd3, 16'h1111, 16'h2222, 8'h33, 1'b0, 16'h0, 0);
        @(negedge clk);
        chk("ill_sel_err_set", sel_err, 1);
        chk("ill_no_out_valid", out_valid, 0);
        @(negedge clk);
        chk("ill_sel_err_sticky", sel_err, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        send(2'd3, 16'h1111, 16'h2222, 8'h33, 1'b0, 16'h0, 0);
        err_clr = 1'b0;
        @(negedge clk);
        chk("ill_set_wins", sel_err, 1);
        chk("ill_in_ready", in_ready, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("ill_cleared", sel_err, 0);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("clr_no_error", sel_err, 0);
        chk("ill_not_forwarded", sb.size(), 0);
        @(posedge clk);
        #1;

        // Streaming: one beat per cycle, each out one cycle after accept
        for (int i = 1; i <= 8; i++)
            send(2'd0, 16'(i), 16'hFFFF, 8'h0, 1'b0, 16'(i), 1);
        drain();

        // Reset with main and skid both full
        out_ready = 1'b0;
        send(2'd0, 16'h1111, 16'h0, 8'h0, 1'b0, 16'h1111, 0);
        send(2'd0, 16'h2222, 16'h0, 8'h0, 1'b0, 16'h2222, 0);
        @(negedge clk);
        chk("mid_full_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 16'h0000);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_stale", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
- Parametrised successor to the writeback datapath select.
- Chooses one of NSRC full-width sources or an extended control-unit immediate.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so a writeback stall never drops data.
- Flags illegal selects instead of driving high-Z. Sits between ALU/memory/control unit and register-file write port.

Parameters:
- DATA_W, 16, width of each source and of out_data.
- IMM_W, 8, width of control-unit immediate (1 ≤ IMM_W ≤ DATA_W).
- NSRC, 2, number of full-width sources (≥ 1).
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ NSRC+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- src_data  input  NSRC*DATA_W  source i in bits [i*DATA_W +: DATA_W] (0 = ALU, 1 = memory).
- imm_data  input  IMM_W  control-unit immediate.
- imm_signed  input  1  1 = sign-extend imm_data, 0 = zero-extend.
- sel  input  SEL_W  select, 0..NSRC-1 = source, NSRC = immediate, others illegal.
- in_valid  input  1  beat present on sel/src_data/imm_data/imm_signed.
- in_ready  output  1  block can accept a beat.
- out_data  output  DATA_W  selected, extended result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- err_clr  input  1  clears sel_err.
- sel_err  output  1  sticky illegal-select flag.

Behaviour:
- Accept: in_valid && in_ready at the rising edge. Transfer: out_valid && out_ready at the rising edge.
- Select/extend is combinational on the input side and captured at accept.
  - sel < NSRC: captures src_data slice sel.
  - sel == NSRC: captures imm_data, extended to DATA_W by replicating bit IMM_W-1 (imm_signed=1) or with zeros (imm_signed=0). IMM_W == DATA_W means no extension.
- Storage: main register (drives out_data/out_valid) plus skid register.
- in_ready = !skid_valid && !rst (combinational from registered state; never depends on in_valid).
- Latency: accepted beat appears on out_data on the next cycle when main is empty or transferring. Throughput 1 beat/cycle with out_ready held high.
- Per-edge cases, main M, skid S:
  - Accept, M empty: M <= beat.
  - Accept, M full, transfer: M <= beat.
  - Accept, M full, no transfer: S <= beat. in_ready low from the next cycle.
  - No accept, transfer, S full: M <= S, S empties.
  - No accept, transfer, S empty: M empties.
  - Transfer with S full and in_ready low: M <= S. A new beat cannot be accepted that cycle.
- Ordering: strict FIFO; no beat is lost or duplicated. out_data holds stable while out_valid && !out_ready.
- Illegal sel (sel > NSRC) with accept: beat is consumed (in_ready unaffected), not forwarded, sel_err <= 1.
- sel_err:
  - Stays set until err_clr.
  - err_clr and a new illegal accept on the same edge: set wins.
  - err_clr with no error: no effect.
- Inputs with in_valid low are ignored regardless of sel.
- Reset, also mid-operation with M/S full: next edge clears out_valid, skid_valid, sel_err, and sets out_data and skid data to 0. Pending beats are discarded. in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- No X or Z ever driven on outputs after the first reset.

Decomposition:
- Package wb_pkg holds:
  - SEL_ALU = 0, SEL_MEM = 1 (source index constants).
  - Function sel_imm(NSRC) returning the immediate index.
  - Function ext_imm(imm, signed, DATA_W, IMM_W).
- Sub-module wb_skid_buffer (parameter W): generic 2-entry valid/ready skid register, reusable elsewhere in the pipeline. wb_select_pipe = select/extend logic + error flag + one wb_skid_buffer instance.

Test Plan:
Defaults (DATA_W=16, IMM_W=8, NSRC=2).
1. Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_data=0x0000, sel_err=0, in_ready=0. Cycle after release -> in_ready=1.
2. Extension: sel=2, imm_data=0x80, imm_signed=1 -> out_data=0xFF80 one cycle later. Same with imm_signed=0 -> 0x0080. sel=0, ALU=0x1234 -> 0x1234. sel=1, mem=0xBEEF -> 0xBEEF.
3. Backpressure: out_ready=0, push ALU 0x1234 then mem 0xBEEF.
   - in_ready=0 after second accept; third beat held off.
   - Raise out_ready -> 0x1234, then 0xBEEF, then third beat, on consecutive cycles, none lost.
4. Illegal select: sel=3 accepted -> no out_valid, sel_err=1 next cycle and stays.
   - err_clr=1 on the same edge as another sel=3 accept -> sel_err stays 1.
   - err_clr alone -> 0.
5. Streaming: 8 back-to-back beats, ALU=0x0001..0x0008, out_ready=1 -> 8 outputs on 8 consecutive cycles, each 1 cycle after its accept.
6. Reset mid-operation: M and S full (out_ready=0), assert rst 1 cycle -> out_valid=0, in_ready=1 after release, no stale beat emitted.
